// File: rtl/dct_sequencer.sv
// dct_sequencer: steps one 8x8 forward-DCT block through a shared MAC datapath and hands out coefficients.
// Build option: define DCT_SEQ_ZIGZAG_EN for JPEG zigzag emission order (raster order otherwise).
module dct_sequencer #(
  parameter int MAC_LAT = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       abort,
  input  logic       start_valid,
  output logic       start_ready,
  output logic [5:0] pix_addr,
  output logic [5:0] cos_a_idx,
  output logic [5:0] cos_b_idx,
  output logic       acc_en,
  output logic       acc_clr,
  output logic       coef_valid,
  input  logic       coef_ready,
  output logic [2:0] coef_u,
  output logic [2:0] coef_v,
  output logic [5:0] coef_idx,
  output logic       block_done
);

  typedef enum logic [2:0] {IDLE, ACCUM, DRAIN, EMIT, DONE} state_t;

  localparam logic [2:0] DRAIN_LAST = (MAC_LAT > 0) ? 3'(MAC_LAT - 1) : 3'd0;

  state_t     state_q;
  logic [2:0] row_q;
  logic [2:0] col_q;
  logic [2:0] drainCnt_q;
  logic [5:0] coefIdx_q;
  logic [2:0] u_q;
  logic [2:0] v_q;
  logic       startReady_q;
  logic       accEn_q;
  logic       accClr_q;
  logic       coefValid_q;
  logic       blockDone_q;

  logic [5:0] nextIdx_d;
  logic [5:0] nextUv_d;
  logic [5:0] firstUv_d;
  logic       lastPix_d;
  logic       lastCoef_d;

  // Maps an emission sequence number to the {u,v} frequency pair it presents.
  function automatic logic [5:0] mapCoef(input logic [5:0] idx);
`ifdef DCT_SEQ_ZIGZAG_EN
    logic [5:0] pos;
    case (idx)
      6'd0:  pos = 6'd0;
      6'd1:  pos = 6'd1;
      6'd2:  pos = 6'd8;
      6'd3:  pos = 6'd16;
      6'd4:  pos = 6'd9;
      6'd5:  pos = 6'd2;
      6'd6:  pos = 6'd3;
      6'd7:  pos = 6'd10;
      6'd8:  pos = 6'd17;
      6'd9:  pos = 6'd24;
      6'd10: pos = 6'd32;
      6'd11: pos = 6'd25;
      6'd12: pos = 6'd18;
      6'd13: pos = 6'd11;
      6'd14: pos = 6'd4;
      6'd15: pos = 6'd5;
      6'd16: pos = 6'd12;
      6'd17: pos = 6'd19;
      6'd18: pos = 6'd26;
      6'd19: pos = 6'd33;
      6'd20: pos = 6'd40;
      6'd21: pos = 6'd48;
      6'd22: pos = 6'd41;
      6'd23: pos = 6'd34;
      6'd24: pos = 6'd27;
      6'd25: pos = 6'd20;
      6'd26: pos = 6'd13;
      6'd27: pos = 6'd6;
      6'd28: pos = 6'd7;
      6'd29: pos = 6'd14;
      6'd30: pos = 6'd21;
      6'd31: pos = 6'd28;
      6'd32: pos = 6'd35;
      6'd33: pos = 6'd42;
      6'd34: pos = 6'd49;
      6'd35: pos = 6'd56;
      6'd36: pos = 6'd57;
      6'd37: pos = 6'd50;
      6'd38: pos = 6'd43;
      6'd39: pos = 6'd36;
      6'd40: pos = 6'd29;
      6'd41: pos = 6'd22;
      6'd42: pos = 6'd15;
      6'd43: pos = 6'd23;
      6'd44: pos = 6'd30;
      6'd45: pos = 6'd37;
      6'd46: pos = 6'd44;
      6'd47: pos = 6'd51;
      6'd48: pos = 6'd58;
      6'd49: pos = 6'd59;
      6'd50: pos = 6'd52;
      6'd51: pos = 6'd45;
      6'd52: pos = 6'd38;
      6'd53: pos = 6'd31;
      6'd54: pos = 6'd39;
      6'd55: pos = 6'd46;
      6'd56: pos = 6'd53;
      6'd57: pos = 6'd60;
      6'd58: pos = 6'd61;
      6'd59: pos = 6'd54;
      6'd60: pos = 6'd47;
      6'd61: pos = 6'd55;
      6'd62: pos = 6'd62;
      default: pos = 6'd63;
    endcase
    return pos;
`else
    return idx;
`endif
  endfunction

  always_comb begin
    nextIdx_d  = coefIdx_q + 6'd1;
    nextUv_d   = mapCoef(nextIdx_d);
    firstUv_d  = mapCoef(6'd0);
    lastPix_d  = (row_q == 3'd7) && (col_q == 3'd7);
    lastCoef_d = (coefIdx_q == 6'd63);
  end

  // All outputs come straight from these flops; abort wins over every handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      row_q        <= 3'd0;
      col_q        <= 3'd0;
      drainCnt_q   <= 3'd0;
      coefIdx_q    <= 6'd0;
      u_q          <= 3'd0;
      v_q          <= 3'd0;
      startReady_q <= 1'b1;
      accEn_q      <= 1'b0;
      accClr_q     <= 1'b0;
      coefValid_q  <= 1'b0;
      blockDone_q  <= 1'b0;
    end else if (abort) begin
      state_q      <= IDLE;
      row_q        <= 3'd0;
      col_q        <= 3'd0;
      drainCnt_q   <= 3'd0;
      coefIdx_q    <= 6'd0;
      u_q          <= 3'd0;
      v_q          <= 3'd0;
      startReady_q <= 1'b1;
      accEn_q      <= 1'b0;
      accClr_q     <= 1'b0;
      coefValid_q  <= 1'b0;
      blockDone_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_valid) begin
            state_q      <= ACCUM;
            startReady_q <= 1'b0;
            accEn_q      <= 1'b1;
            accClr_q     <= 1'b1;
            row_q        <= 3'd0;
            col_q        <= 3'd0;
            coefIdx_q    <= 6'd0;
            {u_q, v_q}   <= firstUv_d;
          end
        end
        ACCUM: begin
          accClr_q <= 1'b0;
          col_q    <= col_q + 3'd1;
          if (col_q == 3'd7) begin
            row_q <= row_q + 3'd1;
          end
          if (lastPix_d) begin
            accEn_q <= 1'b0;
            if (MAC_LAT == 0) begin
              state_q     <= EMIT;
              coefValid_q <= 1'b1;
            end else begin
              state_q    <= DRAIN;
              drainCnt_q <= DRAIN_LAST;
            end
          end
        end
        DRAIN: begin
          // Wait for the last product to retire through the MAC pipeline.
          if (drainCnt_q == 3'd0) begin
            state_q     <= EMIT;
            coefValid_q <= 1'b1;
          end else begin
            drainCnt_q <= drainCnt_q - 3'd1;
          end
        end
        EMIT: begin
          if (coef_ready) begin
            coefValid_q <= 1'b0;
            if (lastCoef_d) begin
              state_q     <= DONE;
              blockDone_q <= 1'b1;
            end else begin
              state_q    <= ACCUM;
              accEn_q    <= 1'b1;
              accClr_q   <= 1'b1;
              row_q      <= 3'd0;
              col_q      <= 3'd0;
              coefIdx_q  <= nextIdx_d;
              {u_q, v_q} <= nextUv_d;
            end
          end
        end
        DONE: begin
          state_q      <= IDLE;
          blockDone_q  <= 1'b0;
          startReady_q <= 1'b1;
          coefIdx_q    <= 6'd0;
          u_q          <= 3'd0;
          v_q          <= 3'd0;
        end
        default: begin
          state_q      <= IDLE;
          startReady_q <= 1'b1;
          accEn_q      <= 1'b0;
          accClr_q     <= 1'b0;
          coefValid_q  <= 1'b0;
          blockDone_q  <= 1'b0;
        end
      endcase
    end
  end

  assign start_ready = startReady_q;
  assign pix_addr    = {row_q, col_q};
  assign cos_a_idx   = {u_q, row_q};
  assign cos_b_idx   = {v_q, col_q};
  assign acc_en      = accEn_q;
  assign acc_clr     = accClr_q;
  assign coef_valid  = coefValid_q;
  assign coef_u      = u_q;
  assign coef_v      = v_q;
  assign coef_idx    = coefIdx_q;
  assign block_done  = blockDone_q;

endmodule
